apb_master_n: RTL and testbench
===============================

Name: apb_master_n

Overview:
- Parametrised APB3 bridge between the RV32I core's internal bus (transfer/ready/write/addr/wdata/rdata) and N APB slaves.
- Replaces the fixed six-slave master with a vector-based design:
  - configurable slave count and address window size;
  - decode of unmapped addresses;
  - per-transfer timeout with an error response to the core.
- Sits between CPU_RV32I and the peripheral set (RAM, GPIO, UART, ...) at MCU top level.

Parameters:
- NUM_SLAVES, 6, number of PSEL/PRDATA/PREADY lanes (1..16).
- BASE_ADDR, 32'h1000_0000, start of peripheral region; slot 0 begins here.
- SLOT_LOG2, 12, log2 of window size per slave (default 4 KiB).
- TIMEOUT_CYCLES, 255, max ACCESS-phase cycles without PREADY before abort (1..65535).

Ports:
- PCLK  in  1  clock
- PRESET  in  1  asynchronous, active-low reset
- transfer  in  1  core request pulse, sampled only in IDLE
- write  in  1  1=write, 0=read
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data, valid while ready=1
- ready  out  1  one-cycle completion strobe
- bus_err  out  1  valid with ready; 1 = decode error, timeout or slave error
- PADDR  out  32  latched addr
- PWRITE  out  1  latched write
- PWDATA  out  32  latched wdata
- PENABLE  out  1  APB enable
- PSEL  out  NUM_SLAVES  one-hot select
- PRDATA  in  NUM_SLAVES*32  slave i occupies bits [32*i+31:32*i]
- PREADY  in  NUM_SLAVES  per-slave ready

Behaviour:
- Reset (PRESET=0, async): state=IDLE; ready, bus_err, PENABLE, PWRITE=0; PSEL=0; PADDR, PWDATA, rdata=0; timeout counter=0.
  - Reset mid-transfer aborts immediately; no ready is issued.
- Decode: off = addr - BASE_ADDR; idx = off >> SLOT_LOG2.
  - Mapped iff addr >= BASE_ADDR and idx < NUM_SLAVES. Compare is unsigned 32-bit, no wrap.
- States: IDLE, SETUP, ACCESS, ERR.
- IDLE, transfer=1:
  - Latch addr, write, wdata into PADDR/PWRITE/PWDATA, and idx into sel_q.
  - Mapped -> SETUP; unmapped -> ERR. No PSEL asserted.
- SETUP: PSEL[sel_q]=1, PENABLE=0; counter cleared; -> ACCESS unconditionally.
- ACCESS: PSEL[sel_q]=1, PENABLE=1.
  - PREADY[sel_q]=1: ready=1, bus_err=0, rdata=PRDATA lane sel_q (combinational, same cycle), then -> IDLE.
  - Otherwise counter increments. When counter reaches TIMEOUT_CYCLES-1 with no PREADY: ready=1, bus_err=1, rdata=0, then -> IDLE.
- ERR: one cycle; ready=1, bus_err=1, rdata=0; -> IDLE.
- Writes: rdata=0 on completion.
- Timing:
  - Minimum mapped latency: transfer in cycle 0, ready in cycle 2.
  - Decode error: ready in cycle 1.
  - Timeout with TIMEOUT_CYCLES=T: ready in cycle 1+T.
- transfer asserted outside IDLE is ignored and not queued. The next request is accepted only in IDLE, one cycle after ready at the earliest.
- PADDR/PWRITE/PWDATA hold their values after completion until the next accepted transfer.
- Only lane sel_q's PREADY/PRDATA are observed. Other lanes' PREADY are don't-care.

Optional Feature:
- Macro: APB_PSLVERR_EN.
- Defined:
  - Adds input port PSLVERR [NUM_SLAVES-1:0].
  - In ACCESS, when PREADY[sel_q]=1: bus_err = PSLVERR[sel_q]. For reads with PSLVERR=1, rdata is forced to 0.
- Not defined:
  - Port absent.
  - bus_err is raised only by decode error or timeout.

Test Plan:
- Read slot 2 (addr=32'h1000_2010); PREADY[2]=1 immediately; PRDATA lane 2=32'hCAFE_0002 -> PSEL=6'b000100 in cycles 1-2, PENABLE=1 in cycle 2; ready=1, rdata=32'hCAFE_0002, bus_err=0 in cycle 2.
- Write addr=32'h1000_5004, wdata=32'h1234_5678; slave 5 holds PREADY low for 3 ACCESS cycles -> PWDATA/PADDR stable throughout; ready in cycle 5; PSEL=6'b100000.
- Unmapped addr=32'h1000_6000 and addr=32'h0FFF_FFFC -> no PSEL; ready=1, bus_err=1, rdata=0 in cycle 1.
- TIMEOUT_CYCLES=4; slave 0 never ready -> ready=1, bus_err=1 in cycle 5; PSEL returns to 0 in cycle 6; next transfer accepted normally.
- transfer pulsed during ACCESS, then PRESET low mid-ACCESS -> extra request ignored; on reset all outputs 0 immediately, state IDLE, no ready.
- APB_PSLVERR_EN build: slave 3 returns PREADY=1, PSLVERR=1 on a read -> ready=1, bus_err=1, rdata=0.

Source files
------------

// File: rtl/apb_master_n_if.sv
// Core-side request/response and APB3 bus bundle for apb_master_n.
// APB_PSLVERR_EN adds the per-slave PSLVERR lanes to both modports.
interface apb_master_n_if #(
    parameter int unsigned NUM_SLAVES = 6
);
    logic                       transfer;
    logic                       write;
    logic [31:0]                addr;
    logic [31:0]                wdata;
    logic [31:0]                rdata;
    logic                       ready;
    logic                       bus_err;

    logic [31:0]                PADDR;
    logic                       PWRITE;
    logic [31:0]                PWDATA;
    logic                       PENABLE;
    logic [NUM_SLAVES-1:0]      PSEL;
    logic [NUM_SLAVES*32-1:0]   PRDATA;
    logic [NUM_SLAVES-1:0]      PREADY;
`ifdef APB_PSLVERR_EN
    logic [NUM_SLAVES-1:0]      PSLVERR;

    modport master (
        input  transfer, write, addr, wdata, PRDATA, PREADY, PSLVERR,
        output rdata, ready, bus_err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );
    modport slave (
        output transfer, write, addr, wdata, PRDATA, PREADY, PSLVERR,
        input  rdata, ready, bus_err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );
`else
    modport master (
        input  transfer, write, addr, wdata, PRDATA, PREADY,
        output rdata, ready, bus_err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );
    modport slave (
        output transfer, write, addr, wdata, PRDATA, PREADY,
        input  rdata, ready, bus_err, PADDR, PWRITE, PWDATA, PENABLE, PSEL
    );
`endif
endinterface

// File: rtl/apb_master_n.sv
// APB3 bridge from the core bus to NUM_SLAVES windowed slaves, with decode error and ACCESS timeout.
// Latency: ready 2 cycles after transfer (mapped, zero wait), 1 cycle on decode error, 1+TIMEOUT_CYCLES on timeout.
// Backpressure: slave stalls via PREADY; new requests are taken only in IDLE. Optional macro APB_PSLVERR_EN.
module apb_master_n #(
    parameter int unsigned NUM_SLAVES     = 6,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int unsigned SLOT_LOG2      = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_master_n_if.master bus
);
    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [31:0]           paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;

    logic [31:0] off;
    logic [31:0] idx;
    logic        mapped;
    logic        lane_rdy;
    logic        lane_err;
    logic [31:0] lane_dat;
    logic        timeout;
    logic        ready;
    logic        bus_err;
    logic [31:0] rdata;

    // Unsigned compare on addr guards against the subtraction wrapping below BASE_ADDR.
    always_comb begin
        off    = bus.addr - BASE_ADDR;
        idx    = off >> SLOT_LOG2;
        mapped = (bus.addr >= BASE_ADDR) && (idx < NUM_SLAVES);
    end

    assign lane_rdy = bus.PREADY[sel_q];
    assign lane_dat = bus.PRDATA[32*sel_q +: 32];
`ifdef APB_PSLVERR_EN
    assign lane_err = bus.PSLVERR[sel_q];
`else
    assign lane_err = 1'b0;
`endif
    assign timeout = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        ready     = 1'b0;
        bus_err   = 1'b0;
        rdata     = 32'h0;
        case (state_q)
            IDLE: begin
                if (bus.transfer) begin
                    paddr_d  = bus.addr;
                    pwrite_d = bus.write;
                    pwdata_d = bus.wdata;
                    sel_d    = idx[SEL_W-1:0];
                    if (mapped) begin
                        state_d = SETUP;
                        psel_d  = NUM_SLAVES'(1) << idx[SEL_W-1:0];
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = 16'h0;
            end
            ACCESS: begin
                // A ready slave wins over an expiring timeout in the same cycle.
                if (lane_rdy) begin
                    ready     = 1'b1;
                    bus_err   = lane_err;
                    rdata     = (pwrite_q || lane_err) ? 32'h0 : lane_dat;
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end else if (timeout) begin
                    ready     = 1'b1;
                    bus_err   = 1'b1;
                    state_d   = IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            ERR: begin
                ready   = 1'b1;
                bus_err = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= 16'h0;
            paddr_q   <= 32'h0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= 32'h0;
            psel_q    <= '0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    assign bus.ready   = ready;
    assign bus.bus_err = bus_err;
    assign bus.rdata   = rdata;
    assign bus.PADDR   = paddr_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
endmodule

// File: tb/tb_apb_master_n.sv
// Directed bench for apb_master_n (6 slaves, TIMEOUT_CYCLES=4); cycle 0 is the cycle transfer is high.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_apb_master_n;
    logic PCLK;
    logic PRESET;
    int   n_chk;
    int   n_pass;

    apb_master_n_if #(.NUM_SLAVES(6)) bus ();

    apb_master_n #(
        .NUM_SLAVES    (6),
        .BASE_ADDR     (32'h1000_0000),
        .SLOT_LOG2     (12),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK  (PCLK),
        .PRESET(PRESET),
        .bus   (bus.master)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic next();
        @(posedge PCLK);
        #1;
    endtask

    task automatic sample();
        @(negedge PCLK);
    endtask

    task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        bus.transfer = 1'b1;
        bus.write    = wr;
        bus.addr     = a;
        bus.wdata    = wd;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        PRESET = 1'b0;
        bus.transfer = 1'b0;
        bus.write    = 1'b0;
        bus.addr     = 32'h0;
        bus.wdata    = 32'h0;
        bus.PREADY   = 6'b0;
        for (int i = 0; i < 6; i++) bus.PRDATA[32*i +: 32] = 32'hCAFE_0000 + i;
`ifdef APB_PSLVERR_EN
        bus.PSLVERR = 6'b0;
`endif
        repeat (2) next();
        sample();
        check("rst psel",    32'(bus.PSEL),    32'h0);
        check("rst penable", 32'(bus.PENABLE), 32'h0);
        check("rst ready",   32'(bus.ready),   32'h0);
        check("rst paddr",   bus.PADDR,        32'h0);
        check("rst pwdata",  bus.PWDATA,       32'h0);
        check("rst rdata",   bus.rdata,        32'h0);
        next();
        PRESET = 1'b1;

        // Read slot 2, zero wait states
        next();
        req(1'b0, 32'h1000_2010, 32'h0);
        bus.PREADY = 6'b000100;
        sample();
        check("rd c0 psel",  32'(bus.PSEL),  32'h0);
        check("rd c0 ready", 32'(bus.ready), 32'h0);
        next();
        bus.transfer = 1'b0;
        sample();
        check("rd c1 psel",    32'(bus.PSEL),    32'h04);
        check("rd c1 penable", 32'(bus.PENABLE), 32'h0);
        check("rd c1 ready",   32'(bus.ready),   32'h0);
        next();
        sample();
        check("rd c2 psel",    32'(bus.PSEL),    32'h04);
        check("rd c2 penable", 32'(bus.PENABLE), 32'h1);
        check("rd c2 ready",   32'(bus.ready),   32'h1);
        check("rd c2 rdata",   bus.rdata,        32'hCAFE_0002);
        check("rd c2 err",     32'(bus.bus_err), 32'h0);
        next();
        bus.PREADY = 6'b0;
        sample();
        check("rd c3 psel",  32'(bus.PSEL),  32'h0);
        check("rd c3 ready", 32'(bus.ready), 32'h0);
        check("rd c3 paddr", bus.PADDR,      32'h1000_2010);

        // Write slot 5, three wait states; other lanes' PREADY high must be ignored
        next();
        req(1'b1, 32'h1000_5004, 32'h1234_5678);
        sample();
        next();
        bus.transfer = 1'b0;
        bus.PREADY   = 6'b011111;
        sample();
        check("wr c1 psel", 32'(bus.PSEL), 32'h20);
        for (int c = 2; c <= 4; c++) begin
            next();
            sample();
            check($sformatf("wr c%0d ready", c),  32'(bus.ready),   32'h0);
            check($sformatf("wr c%0d psel", c),   32'(bus.PSEL),    32'h20);
            check($sformatf("wr c%0d paddr", c),  bus.PADDR,        32'h1000_5004);
            check($sformatf("wr c%0d pwdata", c), bus.PWDATA,       32'h1234_5678);
            check($sformatf("wr c%0d pwrite", c), 32'(bus.PWRITE),  32'h1);
        end
        next();
        bus.PREADY = 6'b100000;
        sample();
        check("wr c5 ready", 32'(bus.ready),   32'h1);
        check("wr c5 err",   32'(bus.bus_err), 32'h0);
        check("wr c5 rdata", bus.rdata,        32'h0);
        next();
        bus.PREADY = 6'b0;
        sample();
        check("wr c6 ready",  32'(bus.ready),  32'h0);
        check("wr c6 pwdata", bus.PWDATA,      32'h1234_5678);
        check("wr c6 pwrite", 32'(bus.PWRITE), 32'h1);

        // Unmapped: past last slot, and just below BASE_ADDR
        for (int k = 0; k < 2; k++) begin
            next();
            req(1'b0, (k == 0) ? 32'h1000_6000 : 32'h0FFF_FFFC, 32'h0);
            bus.PREADY = 6'b111111;
            sample();
            next();
            bus.transfer = 1'b0;
            sample();
            check($sformatf("dec%0d c1 ready", k), 32'(bus.ready),   32'h1);
            check($sformatf("dec%0d c1 err", k),   32'(bus.bus_err), 32'h1);
            check($sformatf("dec%0d c1 rdata", k), bus.rdata,        32'h0);
            check($sformatf("dec%0d c1 psel", k),  32'(bus.PSEL),    32'h0);
            next();
            bus.PREADY = 6'b0;
            sample();
            check($sformatf("dec%0d c2 ready", k), 32'(bus.ready), 32'h0);
        end

        // Timeout on slave 0
        next();
        req(1'b0, 32'h1000_0000, 32'h0);
        bus.PREADY = 6'b111110;
        sample();
        next();
        bus.transfer = 1'b0;
        sample();
        for (int c = 2; c <= 4; c++) begin
            next();
            sample();
            check($sformatf("to c%0d ready", c), 32'(bus.ready), 32'h0);
        end
        next();
        sample();
        check("to c5 ready", 32'(bus.ready),   32'h1);
        check("to c5 err",   32'(bus.bus_err), 32'h1);
        check("to c5 rdata", bus.rdata,        32'h0);
        check("to c5 psel",  32'(bus.PSEL),    32'h01);
        next();
        bus.PREADY = 6'b0;
        sample();
        check("to c6 psel",  32'(bus.PSEL),  32'h0);
        check("to c6 ready", 32'(bus.ready), 32'h0);
        next();
        req(1'b0, 32'h1000_1000, 32'h0);
        bus.PREADY = 6'b000010;
        sample();
        next();
        bus.transfer = 1'b0;
        sample();
        next();
        sample();
        check("to next ready", 32'(bus.ready),   32'h1);
        check("to next rdata", bus.rdata,        32'hCAFE_0001);
        check("to next err",   32'(bus.bus_err), 32'h0);

        // Transfer during ACCESS is dropped; async reset mid-ACCESS
        next();
        bus.transfer = 1'b0;
        bus.PREADY   = 6'b0;
        req(1'b0, 32'h1000_4000, 32'h0);
        sample();
        next();
        bus.transfer = 1'b0;
        sample();
        next();
        req(1'b1, 32'h1000_3000, 32'hDEAD_BEEF);
        sample();
        next();
        bus.transfer = 1'b0;
        sample();
        check("ign paddr",  bus.PADDR,        32'h1000_4000);
        check("ign psel",   32'(bus.PSEL),    32'h10);
        check("ign pwrite", 32'(bus.PWRITE),  32'h0);
        #2;
        PRESET     = 1'b0;
        bus.PREADY = 6'b010000;
        #1;
        check("arst psel",    32'(bus.PSEL),    32'h0);
        check("arst penable", 32'(bus.PENABLE), 32'h0);
        check("arst ready",   32'(bus.ready),   32'h0);
        check("arst paddr",   bus.PADDR,        32'h0);
        check("arst rdata",   bus.rdata,        32'h0);
        next();
        next();
        PRESET = 1'b1;
        sample();
        check("post psel",  32'(bus.PSEL),  32'h0);
        check("post ready", 32'(bus.ready), 32'h0);
        next();
        bus.PREADY = 6'b000100;
        req(1'b0, 32'h1000_2000, 32'h0);
        sample();
        next();
        bus.transfer = 1'b0;
        sample();
        check("post c1 psel", 32'(bus.PSEL), 32'h04);
        next();
        sample();
        check("post c2 ready", 32'(bus.ready), 32'h1);
        check("post c2 rdata", bus.rdata,      32'hCAFE_0002);
        next();
        bus.PREADY = 6'b0;

`ifdef APB_PSLVERR_EN
        next();
        req(1'b0, 32'h1000_3000, 32'h0);
        bus.PREADY  = 6'b001000;
        bus.PSLVERR = 6'b001000;
        sample();
        next();
        bus.transfer = 1'b0;
        sample();
        next();
        sample();
        check("slverr ready", 32'(bus.ready),   32'h1);
        check("slverr err",   32'(bus.bus_err), 32'h1);
        check("slverr rdata", bus.rdata,        32'h0);
        next();
        bus.PREADY  = 6'b0;
        bus.PSLVERR = 6'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
